// File: rtl/preg_wb_arbiter.sv
// preg_wb_arbiter: writeback arbiter for the banked physical register file.
// Routes up to NREQ functional-unit results to WNUM register-file write
// ports. The bank is selected by the low address bits. Each bank has its own
// round-robin arbiter, and the winner of each bank goes through one register
// stage to the write port.
//
// Optional feature macro: PREG_WB_ARB_STATS_EN adds the conflict_cnt
// stall counter and its port.
//
// Ports:
//   clk           clock, all state on rising edge
//   reset         asynchronous active-high reset
//   req_valid     per-requester result valid
//   req_addr      per-requester destination physical register
//   req_data      per-requester result value
//   req_ready     per-requester accept (combinational)
//   wvalid        per-bank write enable (registered)
//   wa            per-bank full write address (registered, held when idle)
//   wdata         per-bank write data (registered, held when idle)
//   conflict_cnt  saturating count of stalled request-cycles (stats build only)
module preg_wb_arbiter #(
    parameter type         T    = logic [63:0],
    parameter int unsigned NREQ = 6,
    parameter int unsigned WNUM = 4,
    parameter int unsigned QLEN = 64
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NREQ-1:0]                            req_valid,
    input  logic [NREQ-1:0][$clog2(QLEN)-1:0]          req_addr,
    input  logic [NREQ-1:0][$bits(T)-1:0]              req_data,
    output logic [NREQ-1:0]                            req_ready,
    output logic [WNUM-1:0]                            wvalid,
    output logic [WNUM-1:0][$clog2(QLEN)-1:0]          wa,
    output logic [WNUM-1:0][$bits(T)-1:0]              wdata
`ifdef PREG_WB_ARB_STATS_EN
    ,
    output logic [31:0]                                conflict_cnt
`endif
);

    localparam int unsigned AW = $clog2(QLEN);
    localparam int unsigned DW = $bits(T);
    localparam int unsigned BW = $clog2(WNUM);
    localparam int unsigned PW = $clog2(NREQ);

    logic [WNUM-1:0][PW-1:0]   ptr_q;
    logic [WNUM-1:0][PW-1:0]   gnt_idx;
    logic [WNUM-1:0]           gnt_any;
    logic [WNUM-1:0][NREQ-1:0] cand;

    // (base + k) mod NREQ without a divider; base < NREQ and k < NREQ
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base,
                                             input int unsigned   k);
        logic [PW:0] s;
        s = {1'b0, base} + (PW+1)'(k);
        if (s >= (PW+1)'(NREQ)) begin
            s = s - (PW+1)'(NREQ);
        end
        return s[PW-1:0];
    endfunction

    // Per-bank candidate sets, round-robin pick and ready fan-back
    always_comb begin
        cand      = '0;
        gnt_idx   = '0;
        gnt_any   = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < WNUM; i++) begin
            for (int unsigned r = 0; r < NREQ; r++) begin
                cand[i][r] = req_valid[r] && !reset &&
                             (req_addr[r][BW-1:0] == BW'(i));
            end
        end
        for (int unsigned i = 0; i < WNUM; i++) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!gnt_any[i] && cand[i][rr_idx(ptr_q[i], k)]) begin
                    gnt_any[i] = 1'b1;
                    gnt_idx[i] = rr_idx(ptr_q[i], k);
                end
            end
        end
        // each requester belongs to exactly one bank, so no double set
        for (int unsigned i = 0; i < WNUM; i++) begin
            if (gnt_any[i]) begin
                req_ready[gnt_idx[i]] = 1'b1;
            end
        end
    end

    // Pointer update and write-port register stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            wvalid <= '0;
            wa     <= '0;
            wdata  <= '0;
        end else begin
            for (int unsigned i = 0; i < WNUM; i++) begin
                wvalid[i] <= gnt_any[i];
                if (gnt_any[i]) begin
                    ptr_q[i] <= (gnt_idx[i] == PW'(NREQ - 1)) ? '0
                                                              : gnt_idx[i] + PW'(1);
                    wa[i]    <= req_addr[gnt_idx[i]];
                    wdata[i] <= req_data[gnt_idx[i]];
                end
            end
        end
    end

`ifdef PREG_WB_ARB_STATS_EN
    localparam int unsigned CW = $clog2(NREQ + 1);

    logic [CW-1:0] stall_num;
    logic [32:0]   cnt_sum;

    // Number of requesters left waiting this cycle
    always_comb begin
        stall_num = '0;
        for (int unsigned r = 0; r < NREQ; r++) begin
            stall_num = stall_num + CW'(req_valid[r] && !req_ready[r]);
        end
        cnt_sum = {1'b0, conflict_cnt} + 33'(stall_num);
    end

    // Saturating accumulation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else begin
            conflict_cnt <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_preg_wb_arbiter.sv
// Directed testbench for preg_wb_arbiter (default parameters: NREQ=6,
// WNUM=4, QLEN=64, 64-bit data). Inputs change 1 time unit after a rising
// edge; ready is sampled before the next edge, and registered outputs are
// sampled 1 time unit after the edge.
module tb_preg_wb_arbiter;

    logic             clk;
    logic             reset;
    logic [5:0]       req_valid;
    logic [5:0][5:0]  req_addr;
    logic [5:0][63:0] req_data;
    logic [5:0]       req_ready;
    logic [3:0]       wvalid;
    logic [3:0][5:0]  wa;
    logic [3:0][63:0] wdata;
`ifdef PREG_WB_ARB_STATS_EN
    logic [31:0]      conflict_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    preg_wb_arbiter #(
        .T    (logic [63:0]),
        .NREQ (6),
        .WNUM (4),
        .QLEN (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wvalid       (wvalid),
        .wa           (wa),
        .wdata        (wdata)
`ifdef PREG_WB_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_reqs();
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int r, input logic [5:0] a, input logic [63:0] d);
        req_valid[r] = 1'b1;
        req_addr[r]  = a;
        req_data[r]  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        clear_reqs();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        logic [23:0] wa_exp;
        reset = 1'b1;
        clear_reqs();
        set_req(0, 6'd8, 64'h11);
        #2;
        n_checks++;
        if (wvalid !== 4'b0000) begin
            n_fail++; $display("FAIL reset_wvalid: got %b want 0000", wvalid);
        end
        n_checks++;
        if (req_ready !== 6'b000000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 000000", req_ready);
        end
        wa_exp = '0;
        n_checks++;
        if (wa !== wa_exp || wdata !== '0) begin
            n_fail++; $display("FAIL reset_wa_wdata: got wa=%h wdata=%h want 0", wa, wdata);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 6'b000001) begin
            n_fail++; $display("FAIL first_grant_ready: got %b want 000001", req_ready);
        end
        next_cycle();
        n_checks++;
        if (wvalid !== 4'b0001 || wa[0] !== 6'd8) begin
            n_fail++; $display("FAIL first_grant_write: got wvalid=%b wa0=%0d want 0001/8", wvalid, wa[0]);
        end
        // mid-stream reset: pending write discarded, ready forced low at once
        reset = 1'b1;
        #1;
        n_checks++;
        if (wvalid !== 4'b0000 || req_ready !== 6'b000000) begin
            n_fail++; $display("FAIL midreset: got wvalid=%b ready=%b want 0000/000000", wvalid, req_ready);
        end
        set_req(2, 6'd8, 64'h22);
        set_req(1, 6'd5, 64'h33);
        set_req(4, 6'd13, 64'h44);
        reset = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 6'b000011) begin
            n_fail++; $display("FAIL post_reset_lowest: got %b want 000011", req_ready);
        end
        next_cycle();
        n_checks++;
        if (wvalid !== 4'b0011 || wa[0] !== 6'd8 || wa[1] !== 6'd5 || wdata[1] !== 64'h33) begin
            n_fail++; $display("FAIL post_reset_write: got wvalid=%b wa0=%0d wa1=%0d wd1=%h", wvalid, wa[0], wa[1], wdata[1]);
        end
        clear_reqs();
    endtask

    task automatic test_parallel();
        logic [23:0] wa_exp;
        pulse_reset();
        for (int r = 0; r < 4; r++) begin
            set_req(r, 6'(4 + 5 * r), 64'h1000 + 64'(r));
        end
        #1;
        n_checks++;
        if (req_ready !== 6'b001111) begin
            n_fail++; $display("FAIL parallel_ready: got %b want 001111", req_ready);
        end
        next_cycle();
        clear_reqs();
        wa_exp = {6'd19, 6'd14, 6'd9, 6'd4};
        n_checks++;
        if (wvalid !== 4'b1111 || wa !== wa_exp) begin
            n_fail++; $display("FAIL parallel_write: got wvalid=%b wa=%h want 1111/%h", wvalid, wa, wa_exp);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wdata[i] !== 64'h1000 + 64'(i)) begin
                n_fail++; $display("FAIL parallel_wdata%0d: got %h want %h", i, wdata[i], 64'h1000 + 64'(i));
            end
        end
    endtask

    task automatic test_conflict_rr();
        logic [5:0]  rdy_exp [4];
        logic [63:0] dat_exp [4];
        rdy_exp = '{6'b000001, 6'b000100, 6'b100000, 6'b000001};
        dat_exp = '{64'hA0, 64'hA2, 64'hA5, 64'hA0};
        pulse_reset();
        set_req(0, 6'd8, 64'hA0);
        set_req(2, 6'd8, 64'hA2);
        set_req(5, 6'd8, 64'hA5);
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (req_ready !== rdy_exp[c]) begin
                n_fail++; $display("FAIL rr_ready_c%0d: got %b want %b", c, req_ready, rdy_exp[c]);
            end
            next_cycle();
            n_checks++;
            if (wvalid[0] !== 1'b1 || wa[0] !== 6'd8 || wdata[0] !== dat_exp[c]) begin
                n_fail++; $display("FAIL rr_write_c%0d: got wv=%b wa=%0d wd=%h want 1/8/%h", c, wvalid[0], wa[0], wdata[0], dat_exp[c]);
            end
        end
        clear_reqs();
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        set_req(1, 6'd6, 64'hD1);
        set_req(3, 6'd10, 64'hD3);
        #1;
        n_checks++;
        if (req_ready !== 6'b000010) begin
            n_fail++; $display("FAIL bp_ready0: got %b want 000010", req_ready);
        end
        next_cycle();
        req_valid[1] = 1'b0;
        n_checks++;
        if (wvalid[2] !== 1'b1 || wa[2] !== 6'd6 || wdata[2] !== 64'hD1) begin
            n_fail++; $display("FAIL bp_write0: got wv=%b wa=%0d wd=%h want 1/6/d1", wvalid[2], wa[2], wdata[2]);
        end
        #1;
        n_checks++;
        if (req_ready !== 6'b001000) begin
            n_fail++; $display("FAIL bp_ready1: got %b want 001000", req_ready);
        end
        next_cycle();
        clear_reqs();
        n_checks++;
        if (wvalid[2] !== 1'b1 || wa[2] !== 6'd10 || wdata[2] !== 64'hD3) begin
            n_fail++; $display("FAIL bp_write1: got wv=%b wa=%0d wd=%h want 1/10/d3", wvalid[2], wa[2], wdata[2]);
        end
        next_cycle();
        n_checks++;
        if (wvalid !== 4'b0000) begin
            n_fail++; $display("FAIL bp_no_dup: got wvalid=%b want 0000", wvalid);
        end
    endtask

    task automatic test_idle_hold();
        pulse_reset();
        set_req(0, 6'd5, 64'hABCD);
        next_cycle();
        clear_reqs();
        n_checks++;
        if (wvalid !== 4'b0010 || wa[1] !== 6'd5 || wdata[1] !== 64'hABCD) begin
            n_fail++; $display("FAIL idle_write: got wv=%b wa1=%0d wd1=%h want 0010/5/abcd", wvalid, wa[1], wdata[1]);
        end
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            n_checks++;
            if (wvalid !== 4'b0000 || wa[1] !== 6'd5 || wdata[1] !== 64'hABCD) begin
                n_fail++; $display("FAIL idle_hold_c%0d: got wv=%b wa1=%0d wd1=%h want 0000/5/abcd", c, wvalid, wa[1], wdata[1]);
            end
        end
    endtask

    task automatic test_single_stream();
        pulse_reset();
        for (int c = 0; c < 3; c++) begin
            set_req(4, 6'd63, 64'h5000 + 64'(c));
            #1;
            n_checks++;
            if (req_ready !== 6'b010000) begin
                n_fail++; $display("FAIL single_ready_c%0d: got %b want 010000", c, req_ready);
            end
            next_cycle();
            n_checks++;
            if (wvalid !== 4'b1000 || wa[3] !== 6'd63 || wdata[3] !== 64'h5000 + 64'(c)) begin
                n_fail++; $display("FAIL single_write_c%0d: got wv=%b wa3=%0d wd3=%h", c, wvalid, wa[3], wdata[3]);
            end
        end
        clear_reqs();
    endtask

`ifdef PREG_WB_ARB_STATS_EN
    task automatic test_stats();
        pulse_reset();
        n_checks++;
        if (conflict_cnt !== 32'd0) begin
            n_fail++; $display("FAIL stats_reset: got %0d want 0", conflict_cnt);
        end
        set_req(0, 6'd0, 64'h1);
        set_req(1, 6'd4, 64'h2);
        set_req(2, 6'd8, 64'h3);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            n_checks++;
            if (conflict_cnt !== 32'(2 * c)) begin
                n_fail++; $display("FAIL stats_c%0d: got %0d want %0d", c, conflict_cnt, 2 * c);
            end
        end
        clear_reqs();
        next_cycle();
        n_checks++;
        if (conflict_cnt !== 32'd6) begin
            n_fail++; $display("FAIL stats_idle: got %0d want 6", conflict_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_parallel();
        test_conflict_rr();
        test_back_to_back();
        test_idle_hold();
        test_single_stream();
`ifdef PREG_WB_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
